// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, default opcodes and
// the bit range of the opcode field inside an instruction word.
package fetch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StFetch  = 3'd1;
  localparam state_t StWait   = 3'd2;
  localparam state_t StDecode = 3'd3;
  localparam state_t StExec   = 3'd4;
  localparam state_t StUpdate = 3'd5;
  localparam state_t StHalt   = 3'd6;
  localparam state_t StError  = 3'd7;

  localparam logic [3:0] HaltOpDefault = 4'hF;
  localparam logic [3:0] JmpOpDefault  = 4'hE;

  // Opcode field of the instruction word.
  localparam int unsigned OpHi = 15;
  localparam int unsigned OpLo = 12;

endpackage

// File: rtl/fetch_sequencer_ack_timer.sv
// Memory-acknowledge watchdog: a clearable, enabled up-counter whose terminal-count
// flag rises when the count reaches TIMEOUT-1.
//   clk, re : clock and asynchronous active-high reset
//   clr     : synchronous clear (has priority over en)
//   en      : count enable
//   tc      : count == TIMEOUT-1
module ack_timer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic re,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tc = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/update control FSM for a 16-bit program counter.
//   clk, re             : clock and asynchronous active-high reset
//   start, halt_req     : begin/resume fetching, halt after the current instruction retires
//   mem_ack, mem_data   : instruction memory response
//   exec_done, br_taken, br_target : datapath completion and optional redirect
//   pc_out              : PC read-back
//   mem_addr, mem_rd    : instruction memory request
//   pc_re/inc/l/w/r/cs, pc_d : PC controls and load value
//   ir, ir_valid        : instruction register and its DECODE pulse
//   instr_cnt           : retired-instruction counter
//   halted, err         : HALT / ERROR state indicators
// All control outputs are decoded from the registered state only.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 8,
  parameter logic [3:0]  HALT_OP = HaltOpDefault,
  parameter logic [3:0]  JMP_OP  = JmpOpDefault
) (
  input  logic             clk,
  input  logic             re,
  input  logic             start,
  input  logic             halt_req,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             exec_done,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd,
  output logic             pc_re,
  output logic             pc_inc,
  output logic             pc_l,
  output logic             pc_w,
  output logic             pc_r,
  output logic             pc_cs,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] ir,
  output logic             ir_valid,
  output logic [WIDTH-1:0] instr_cnt,
  output logic             halted,
  output logic             err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] target_q;
  logic             load_q;    // UPDATE loads target_q instead of incrementing
  logic [WIDTH-1:0] addr_q;    // fetch address held through WAIT
  logic [3:0]       op;
  logic             tc;

  assign op = ir_q[OpHi:OpLo];

  ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk (clk),
    .re  (re),
    .clr (state_q == StFetch),
    .en  ((state_q == StWait) && !mem_ack && !tc),
    .tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StWait;
      StWait: begin
        // An ACK coinciding with the terminal count still wins.
        if (mem_ack)  state_d = StDecode;
        else if (tc)  state_d = StError;
      end
      StDecode: begin
        if (op == HALT_OP)     state_d = StHalt;
        else if (op == JMP_OP) state_d = StUpdate;
        else                   state_d = StExec;
      end
      StExec:   if (exec_done) state_d = StUpdate;
      StUpdate: state_d = halt_req ? StHalt : StFetch;
      StHalt:   if (start) state_d = StFetch;
      StError:  state_d = StError;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      load_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch) addr_q <= pc_out;
      if ((state_q == StWait) && mem_ack) ir_q <= mem_data;
      if ((state_q == StDecode) && (op == JMP_OP)) begin
        target_q <= {{(WIDTH-12){1'b0}}, ir_q[11:0]};
        load_q   <= 1'b1;
      end
      if ((state_q == StExec) && exec_done) begin
        if (br_taken) target_q <= br_target;
        load_q <= br_taken;
      end
      if (state_q == StUpdate) cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_rd   = 1'b0;
    pc_re    = 1'b0;
    pc_inc   = 1'b0;
    pc_l     = 1'b0;
    pc_w     = 1'b0;
    pc_r     = 1'b0;
    pc_cs    = 1'b0;
    pc_d     = '0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    case (state_q)
      StIdle: begin
        pc_re = 1'b1;
        pc_w  = 1'b1;
        pc_cs = 1'b1;
      end
      StFetch: begin
        pc_r     = 1'b1;
        pc_cs    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = pc_out;
      end
      StWait: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
      end
      StDecode: ir_valid = 1'b1;
      StUpdate: begin
        pc_w   = 1'b1;
        pc_cs  = 1'b1;
        pc_l   = load_q;
        pc_inc = !load_q;
        pc_d   = load_q ? target_q : '0;
      end
      StHalt:  halted = 1'b1;
      StError: err    = 1'b1;
      default: ;
    endcase
  end

  assign ir        = ir_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        re = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic        exec_done = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic [15:0] pc_q;
  logic [15:0] mem_addr, pc_d, ir, instr_cnt;
  logic        mem_rd, pc_re, pc_inc, pc_l, pc_w, pc_r, pc_cs, ir_valid, halted, err;

  int total = 0;
  int bad = 0;
  logic [15:0] m_pc;
  logic [15:0] m_cnt;

  fetch_sequencer #(
    .WIDTH   (16),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .re        (re),
    .start     (start),
    .halt_req  (halt_req),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .exec_done (exec_done),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc_out    (pc_q),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .pc_re     (pc_re),
    .pc_inc    (pc_inc),
    .pc_l      (pc_l),
    .pc_w      (pc_w),
    .pc_r      (pc_r),
    .pc_cs     (pc_cs),
    .pc_d      (pc_d),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .instr_cnt (instr_cnt),
    .halted    (halted),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Program counter the sequencer drives.
  always @(posedge clk) begin
    if (pc_cs && pc_w) begin
      if (pc_re)       pc_q <= 16'h0;
      else if (pc_l)   pc_q <= pc_d;
      else if (pc_inc) pc_q <= pc_q + 16'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: PC after one instruction, from the architectural rules.
  function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic [15:0] instr,
                                           input bit br, input logic [15:0] tgt);
    if (instr[15:12] == 4'hF) return pc;
    if (instr[15:12] == 4'hE) return {4'h0, instr[11:0]};
    return br ? tgt : pc + 16'd1;
  endfunction

  task automatic reset_dut();
    re = 1'b1;
    start = 0; halt_req = 0; mem_ack = 0; exec_done = 0; br_taken = 0;
    repeat (3) step();
    chk("rst_ir", ir, 16'h0);
    chk("rst_cnt", instr_cnt, 16'h0);
    chk("rst_pcre", {pc_re, pc_w, pc_cs}, 3'b111);
    chk("rst_misc", {pc_inc, pc_l, pc_r, mem_rd, ir_valid, halted, err}, 7'b0);
    chk("rst_pc", pc_q, 16'h0);
    re = 1'b0;
    m_pc = 16'h0;
    m_cnt = 16'h0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("go_fetch", {mem_rd, pc_r, halted}, 3'b110);
  endtask

  // One instruction starting with the DUT sampled in FETCH.
  task automatic do_instr(input logic [15:0] instr, input int ack_lat, input int exec_lat,
                          input bit br, input logic [15:0] tgt, input bit hreq, input bit ghost,
                          input logic [15:0] exp_pc, input bit exp_load);
    int n = 0;
    chk("fetch_rd", mem_rd, 1'b1);
    chk("fetch_addr", mem_addr, m_pc);
    halt_req = hreq;
    step(); n++;
    for (int k = 0; k <= ack_lat; k++) begin
      chk("wait_rd", {mem_rd, err}, 2'b10);
      chk("wait_addr", mem_addr, m_pc);
      mem_ack  = (k == ack_lat);
      mem_data = (k == ack_lat) ? instr : ~instr;
      step(); n++;
    end
    mem_ack = 1'b0;
    chk("dec_valid", ir_valid, 1'b1);
    chk("dec_ir", ir, instr);
    if (instr[15:12] == 4'hF) begin
      halt_req = 1'b1;  // no effect while halted
      step();
      step();
      chk("hop_halted", {halted, mem_rd}, 2'b10);
      chk("hop_pc", pc_q, exp_pc);
      chk("hop_cnt", instr_cnt, m_cnt);
      halt_req = 1'b0;
      return;
    end
    if (instr[15:12] != 4'hE) begin
      step(); n++;
      for (int e = 0; e <= exec_lat; e++) begin
        exec_done = (e == exec_lat);
        br_taken  = (e == exec_lat) ? br : ghost;
        br_target = (e == exec_lat) ? tgt : ~tgt;
        step(); n++;
      end
      exec_done = 1'b0;
      br_taken  = 1'b0;
    end else begin
      step(); n++;
    end
    chk("upd_ctl", {pc_w, pc_cs, pc_l, pc_inc}, {2'b11, exp_load, !exp_load});
    if (exp_load) chk("upd_d", pc_d, exp_pc);
    m_pc = exp_pc;
    m_cnt = m_cnt + 16'd1;
    step(); n++;
    chk("ret_pc", pc_q, m_pc);
    chk("ret_cnt", instr_cnt, m_cnt);
    chk("loop_cycles", n, 3 + ack_lat + 1 + ((instr[15:12] == 4'hE) ? 0 : exec_lat + 1));
    if (hreq) chk("ret_halted", {halted, mem_rd}, 2'b10);
    else      chk("ret_fetch", {halted, mem_rd}, 2'b01);
    halt_req = 1'b0;
  endtask

  typedef struct {
    logic [15:0] instr;
    int          ack_lat;
    int          exec_lat;
    bit          br;
    logic [15:0] tgt;
    bit          hreq;
    bit          ghost;
    logic [15:0] exp_pc;
    bit          exp_load;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [15:0] instr, tgt, npc;
    bit br, hreq, ld;
    tbl[0] = '{16'h1234, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[1] = '{16'hE3A0, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h03A0, 1'b1};
    tbl[2] = '{16'h5555, 1, 2, 1'b1, 16'd1000, 1'b0, 1'b1, 16'd1000, 1'b1};
    tbl[3] = '{16'h0042, 7, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd1001, 1'b0};
    tbl[4] = '{16'h2000, 2, 1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd1002, 1'b0};
    tbl[5] = '{16'hF000, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd1002, 1'b0};
    tbl[6] = '{16'h3000, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd1003, 1'b0};

    reset_dut();
    go();
    chk("start_pc", pc_q, 16'h0);
    for (int i = 0; i < 7; i++) begin
      do_instr(tbl[i].instr, tbl[i].ack_lat, tbl[i].exec_lat, tbl[i].br, tbl[i].tgt,
               tbl[i].hreq, tbl[i].ghost, tbl[i].exp_pc, tbl[i].exp_load);
      if (tbl[i].hreq || tbl[i].instr[15:12] == 4'hF) go();
    end

    // Memory never answers: 8 WAIT cycles, then ERROR, which only reset leaves.
    chk("to_fetch", mem_rd, 1'b1);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("to_wait", {mem_rd, err}, 2'b10);
      step();
    end
    chk("to_err", {err, mem_rd, pc_w, pc_l, pc_inc}, 5'b10000);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_stuck", err, 1'b1);
    reset_dut();
    chk("to_cleared", err, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    go();
    do_instr(16'hE777, 0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0777, 1'b1);
    step();
    #3 re = 1'b1;
    #1;
    chk("ar_idle", {mem_rd, pc_re, pc_w, pc_cs}, 4'b0111);
    step();
    chk("ar_pc", pc_q, 16'h0);
    chk("ar_cnt", instr_cnt, 16'h0);
    re = 1'b0;
    m_pc = 16'h0;
    m_cnt = 16'h0;

    // Randomised instruction stream against the reference.
    go();
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      instr = 16'($urandom);
      if (r == 0)      instr[15:12] = 4'hF;
      else if (r <= 2) instr[15:12] = 4'hE;
      else             instr[15:12] = 4'($urandom_range(0, 13));
      br   = 1'($urandom);
      tgt  = 16'($urandom);
      hreq = ($urandom_range(0, 7) == 0);
      npc  = ref_next(m_pc, instr, br, tgt);
      ld   = (instr[15:12] == 4'hE) || (instr[15:12] != 4'hF && br);
      do_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), br, tgt, hreq,
               1'($urandom), npc, ld);
      if (hreq || instr[15:12] == 4'hF) go();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
